// File: rtl/stream_buffer_multi_pkg.sv
// Shared types and constants for the multi-line prefetch stream buffer.
//   phys_t          : physical address type; label width derives from it.
//   sb_state_t      : fetch FSM states.
//   sb_entry_t      : per-slot metadata (valid + label); line data lives in a separate array.
//   axi3_rd_req_t   : AXI3 read request bundle (AR channel + rready).
//   axi3_rd_resp_t  : AXI3 read response bundle (arready + R channel).
package stream_buffer_multi_pkg;

  typedef logic [31:0] phys_t;
  localparam int unsigned PhysWidth = $bits(phys_t);

  localparam int unsigned AxiIdWidth   = 4;
  localparam logic [2:0]  AxiSize4B    = 3'b010;
  localparam logic [1:0]  AxiBurstIncr = 2'b01;

  typedef enum logic [1:0] {
    StIdle,
    StWaitAxiReady,
    StReceiving,
    StDrain
  } sb_state_t;

  // Labels are held zero-extended to phys_t so the type is independent of LINE_WIDTH.
  typedef struct packed {
    logic  valid;
    phys_t label;
  } sb_entry_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0] arid;
    phys_t                 araddr;
    logic [3:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic [1:0]            arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  rready;
  } axi3_rd_req_t;

  typedef struct packed {
    logic                  arready;
    logic [AxiIdWidth-1:0] rid;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
  } axi3_rd_resp_t;

  // Width of a beat index within one line; at least one bit so vectors stay legal.
  function automatic int unsigned beat_idx_width(input int unsigned line_width);
    return (line_width / 32 > 1) ? $clog2(line_width / 32) : 1;
  endfunction

endpackage

// File: rtl/axi3_rd_bus.sv
// AXI3 read channel bundle.
//   req  : driven by the master (AR channel fields, arvalid, rready).
//   resp : driven by the slave (arready, R channel fields).
interface axi3_rd_bus;
  import stream_buffer_multi_pkg::*;

  axi3_rd_req_t  req;
  axi3_rd_resp_t resp;

  modport master (output req, input resp);
  modport slave  (input req, output resp);
endinterface

// File: rtl/sb_entry_queue.sv
// Circular storage of prefetched cache lines.
//   clk, rst       : clock, synchronous active-high reset.
//   flush_i        : clear all valids and pointers (dominates commit/pop).
//   wr_en_i        : write wr_data_i into word wr_beat_i of the fill slot.
//   commit_i       : mark the fill slot valid with commit_label_i, advance fill pointer.
//   pop_i          : invalidate the head slot, advance head pointer.
//   head_o         : head slot metadata; head_line_o its line data.
//   count_o        : number of valid slots.
module sb_entry_queue
  import stream_buffer_multi_pkg::*;
#(
  parameter int unsigned LineWidth  = 256,
  parameter int unsigned Depth      = 4,
  parameter int unsigned LabelWidth = 27,
  localparam int unsigned BeatW     = beat_idx_width(LineWidth),
  localparam int unsigned PtrW      = $clog2(Depth),
  localparam int unsigned CntW      = PtrW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  wr_en_i,
  input  logic [BeatW-1:0]      wr_beat_i,
  input  logic [31:0]           wr_data_i,
  input  logic                  commit_i,
  input  logic [LabelWidth-1:0] commit_label_i,
  input  logic                  pop_i,
  output sb_entry_t             head_o,
  output logic [LineWidth-1:0]  head_line_o,
  output logic [CntW-1:0]       count_o
);

  sb_entry_t             meta_q [Depth];
  sb_entry_t             meta_d [Depth];
  logic [LineWidth-1:0]  line_q [Depth];
  logic [LineWidth-1:0]  line_d [Depth];
  logic [PtrW-1:0]       head_ptr_q, head_ptr_d;
  logic [PtrW-1:0]       fill_ptr_q, fill_ptr_d;
  logic [CntW-1:0]       count_q, count_d;

  always_comb begin
    meta_d     = meta_q;
    line_d     = line_q;
    head_ptr_d = head_ptr_q;
    fill_ptr_d = fill_ptr_q;
    count_d    = count_q;

    // The fill slot is never valid while a burst lands in it, so beats go straight in.
    if (wr_en_i) begin
      line_d[fill_ptr_q][32*wr_beat_i +: 32] = wr_data_i;
    end

    if (flush_i) begin
      for (int i = 0; i < Depth; i++) begin
        meta_d[i].valid = 1'b0;
      end
      head_ptr_d = '0;
      fill_ptr_d = '0;
      count_d    = '0;
    end else begin
      if (commit_i) begin
        meta_d[fill_ptr_q].valid = 1'b1;
        meta_d[fill_ptr_q].label = PhysWidth'(commit_label_i);
        fill_ptr_d               = fill_ptr_q + PtrW'(1);
      end
      if (pop_i) begin
        meta_d[head_ptr_q].valid = 1'b0;
        head_ptr_d               = head_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(commit_i) - CntW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        meta_q[i] <= '0;
      end
      head_ptr_q <= '0;
      fill_ptr_q <= '0;
      count_q    <= '0;
    end else begin
      meta_q     <= meta_d;
      head_ptr_q <= head_ptr_d;
      fill_ptr_q <= fill_ptr_d;
      count_q    <= count_d;
    end
  end

  // Line data carries no reset; validity is tracked in meta_q.
  always_ff @(posedge clk) begin
    line_q <= line_d;
  end

  assign head_o      = meta_q[head_ptr_q];
  assign head_line_o = line_q[head_ptr_q];
  assign count_o     = count_q;

endmodule

// File: rtl/stream_buffer_multi.sv
// Multi-line prefetch stream buffer with an AXI3 read master.
//   clk, rst       : clock, synchronous active-high reset.
//   restart        : flush and re-aim the stream at restart_label+1.
//   lookup_req     : cache probe of lookup_label against the queue head.
//   hit, hit_data  : combinational head match and its line.
//   count          : number of valid lines held.
//   axi3_rd_if     : AXI3 read master port; one burst per line, one outstanding at a time.
module stream_buffer_multi
  import stream_buffer_multi_pkg::*;
#(
  parameter int unsigned LINE_WIDTH        = 256,
  parameter int unsigned DEPTH             = 4,
  parameter int unsigned ARID              = 2,
  localparam int unsigned LINE_BYTE_OFFSET = $clog2(LINE_WIDTH / 8),
  localparam int unsigned LABEL_WIDTH      = PhysWidth - LINE_BYTE_OFFSET,
  localparam int unsigned BURST_LEN        = LINE_WIDTH / 32,
  localparam int unsigned CountW           = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   restart,
  input  logic [LABEL_WIDTH-1:0] restart_label,
  input  logic                   lookup_req,
  input  logic [LABEL_WIDTH-1:0] lookup_label,
  output logic                   hit,
  output logic [LINE_WIDTH-1:0]  hit_data,
  output logic [CountW-1:0]      count,
  axi3_rd_bus.master             axi3_rd_if
);

  localparam int unsigned BeatW = beat_idx_width(LINE_WIDTH);

  sb_state_t              state_q, state_d;
  logic [LABEL_WIDTH-1:0] next_label_q, next_label_d;
  logic [LABEL_WIDTH-1:0] fill_label_q, fill_label_d;
  logic                   stream_on_q, stream_on_d;
  logic [BeatW-1:0]       beat_q, beat_d;

  logic                   wr_en;
  logic                   commit;
  logic                   pop;
  logic                   has_room;
  sb_entry_t              head;
  logic [CountW-1:0]      q_count;
  axi3_rd_req_t           req;
  logic                   rx_beat;
  logic                   rx_last;

  // rid/rresp are not checked: only one burst is ever outstanding.
  logic unused_resp_fields;
  assign unused_resp_fields = ^{axi3_rd_if.resp.rid, axi3_rd_if.resp.rresp};

  sb_entry_queue #(
    .LineWidth  (LINE_WIDTH),
    .Depth      (DEPTH),
    .LabelWidth (LABEL_WIDTH)
  ) u_queue (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (restart),
    .wr_en_i        (wr_en),
    .wr_beat_i      (beat_q),
    .wr_data_i      (axi3_rd_if.resp.rdata),
    .commit_i       (commit),
    .commit_label_i (fill_label_q),
    .pop_i          (pop),
    .head_o         (head),
    .head_line_o    (hit_data),
    .count_o        (q_count)
  );

  assign hit   = lookup_req & head.valid & (head.label == PhysWidth'(lookup_label)) & ~restart;
  assign pop   = hit;
  assign count = q_count;

  // A pop this cycle frees a slot in time for the next fetch.
  assign has_room = (q_count != CountW'(DEPTH)) | pop;

  assign rx_beat = axi3_rd_if.resp.rvalid & req.rready;
  assign rx_last = rx_beat & axi3_rd_if.resp.rlast;

  always_comb begin
    req         = '0;
    req.arid    = AxiIdWidth'(ARID);
    req.araddr  = {next_label_q, {LINE_BYTE_OFFSET{1'b0}}};
    req.arlen   = 4'(BURST_LEN - 1);
    req.arsize  = AxiSize4B;
    req.arburst = AxiBurstIncr;
    req.arvalid = (state_q == StWaitAxiReady);
    req.rready  = (state_q == StReceiving) || (state_q == StDrain);
  end

  assign axi3_rd_if.req = req;

  always_comb begin
    state_d      = state_q;
    next_label_d = next_label_q;
    fill_label_d = fill_label_q;
    stream_on_d  = stream_on_q;
    beat_d       = beat_q;
    wr_en        = 1'b0;
    commit       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!restart && stream_on_q && has_room) begin
          state_d = StWaitAxiReady;
        end
      end
      StWaitAxiReady: begin
        // Without arready a restart only moves next_label; araddr follows it next cycle.
        if (axi3_rd_if.resp.arready) begin
          beat_d       = '0;
          fill_label_d = next_label_q;
          state_d      = restart ? StDrain : StReceiving;
        end
      end
      StReceiving: begin
        if (rx_beat) begin
          beat_d = beat_q + BeatW'(1);
          wr_en  = ~restart;
        end
        if (rx_last) begin
          state_d = StIdle;
          if (!restart) begin
            commit       = 1'b1;
            next_label_d = next_label_q + LABEL_WIDTH'(1);
          end
        end else if (restart) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (rx_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (restart) begin
      next_label_d = restart_label + LABEL_WIDTH'(1);
      stream_on_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      next_label_q <= '0;
      fill_label_q <= '0;
      stream_on_q  <= 1'b0;
      beat_q       <= '0;
    end else begin
      state_q      <= state_d;
      next_label_q <= next_label_d;
      fill_label_q <= fill_label_d;
      stream_on_q  <= stream_on_d;
      beat_q       <= beat_d;
    end
  end

endmodule

// File: tb/tb_stream_buffer_multi.sv
// Randomised bench for stream_buffer_multi against a queue-based reference model.
module tb_stream_buffer_multi;
  import stream_buffer_multi_pkg::*;

  localparam int unsigned LW   = 256;
  localparam int unsigned D    = 4;
  localparam int unsigned LABW = 27;
  localparam int unsigned BL   = LW / 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            restart;
  logic [LABW-1:0] restart_label;
  logic            lookup_req;
  logic [LABW-1:0] lookup_label;
  logic            hit;
  logic [LW-1:0]   hit_data;
  logic [2:0]      count;

  axi3_rd_bus bus ();

  stream_buffer_multi #(
    .LINE_WIDTH (LW),
    .DEPTH      (D),
    .ARID       (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .restart       (restart),
    .restart_label (restart_label),
    .lookup_req    (lookup_req),
    .lookup_label  (lookup_label),
    .hit           (hit),
    .hit_data      (hit_data),
    .count         (count),
    .axi3_rd_if    (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: valid lines in order, head first.
  logic [LABW-1:0] mq[$];
  logic [LABW-1:0] exp_next = '0;
  bit              stream_on = 0;
  bit              os = 0;
  bit              os_discard = 0;
  logic [LABW-1:0] os_label = '0;
  int              os_beat = 0;
  int              ar_gap = 0;
  int              n_ar = 0;

  // Stimulus knobs.
  int              p_restart = 0;
  int              p_lookup = 0;
  int              p_arready = 100;
  int              p_rvalid = 100;
  bit              force_lk = 0;
  logic [LABW-1:0] force_lk_label = '0;
  bit              force_rs = 0;
  logic [LABW-1:0] force_rs_label = '0;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] beat_word(input logic [LABW-1:0] label, input int b);
    return (32'(label) * 32'h9E37_79B1) ^ (32'(b) * 32'h0101_0101) ^ 32'h1357_0000;
  endfunction

  function automatic logic [LW-1:0] line_of(input logic [LABW-1:0] label);
    logic [LW-1:0] l;
    for (int b = 0; b < BL; b++) l[b*32 +: 32] = beat_word(label, b);
    return l;
  endfunction

  task automatic step();
    bit              exp_hit;
    bit              ar_hs;
    bit              r_hs;
    bit              last;
    int              r;
    @(negedge clk);
    // Drive inputs.
    if (force_rs) begin
      restart       = 1'b1;
      restart_label = force_rs_label;
    end else begin
      restart = ($urandom_range(0, 999) < p_restart);
      r = $urandom_range(0, 7);
      if (r == 0) restart_label = '1;
      else if (r == 1) restart_label = 27'h500;
      else restart_label = LABW'($urandom);
    end
    if (force_lk) begin
      lookup_req   = 1'b1;
      lookup_label = force_lk_label;
    end else begin
      lookup_req = ($urandom_range(0, 99) < p_lookup);
      r = $urandom_range(0, 9);
      if (mq.size() > 0 && r < 7) lookup_label = mq[0];
      else if (mq.size() > 1 && r < 9) lookup_label = mq[1];
      else lookup_label = LABW'($urandom);
    end
    bus.resp.arready = ($urandom_range(0, 99) < p_arready);
    bus.resp.rid     = 4'd2;
    bus.resp.rresp   = 2'b00;
    if (os) begin
      bus.resp.rvalid = ($urandom_range(0, 99) < p_rvalid);
      bus.resp.rdata  = beat_word(os_label, os_beat);
      bus.resp.rlast  = (os_beat == BL - 1);
    end else begin
      bus.resp.rvalid = 1'b0;
      bus.resp.rdata  = '0;
      bus.resp.rlast  = 1'b0;
    end
    #1;
    // Compare outputs against the model.
    exp_hit = lookup_req && !restart && mq.size() > 0 && mq[0] == lookup_label;
    check("hit", hit, exp_hit);
    if (exp_hit) check("hit_data", hit_data, line_of(mq[0]));
    check("count", count, mq.size());
    check("rready", bus.req.rready, os);
    if (bus.req.arvalid) begin
      check("araddr", bus.req.araddr, {exp_next, 5'b0});
      check("arlen", bus.req.arlen, BL - 1);
      check("arid", bus.req.arid, 2);
      check("arsize", bus.req.arsize, 3'b010);
      check("arburst", bus.req.arburst, 2'b01);
      check("ar_misc", {bus.req.arlock, bus.req.arcache, bus.req.arprot}, 0);
      check("ar_room", stream_on && !os && mq.size() < D, 1);
    end
    if (stream_on && !os && mq.size() < D && !bus.req.arvalid) ar_gap++;
    else ar_gap = 0;
    check("ar_live", ar_gap > 3, 0);
    // Advance the model across the coming edge.
    ar_hs = bus.req.arvalid && bus.resp.arready;
    r_hs  = bus.resp.rvalid && bus.req.rready;
    last  = bus.resp.rlast;
    if (exp_hit) void'(mq.pop_front());
    if (r_hs) begin
      os_beat++;
      if (last) begin
        os = 0;
        if (!os_discard && !restart) begin
          mq.push_back(os_label);
          exp_next = exp_next + 1'b1;
        end
      end
    end
    if (ar_hs) begin
      n_ar++;
      os         = 1;
      os_label   = exp_next;
      os_beat    = 0;
      os_discard = restart;
    end
    if (restart) begin
      mq.delete();
      exp_next  = restart_label + 1'b1;
      stream_on = 1;
      if (os) os_discard = 1;
    end
  endtask

  initial begin
    rst              = 1'b1;
    restart          = 1'b0;
    restart_label    = '0;
    lookup_req       = 1'b1;
    lookup_label     = '0;
    bus.resp         = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_hit", hit, 0);
    check("rst_count", count, 0);
    check("rst_arvalid", bus.req.arvalid, 0);
    check("rst_rready", bus.req.rready, 0);
    rst = 1'b0;

    // Inactive until the first restart.
    force_lk = 1;
    force_lk_label = '0;
    repeat (8) step();
    force_lk = 0;

    // Restart at 0x100 and let four lines fill.
    force_rs = 1;
    force_rs_label = 27'h100;
    step();
    force_rs = 0;
    repeat (80) step();
    check("fill_bursts", n_ar, 4);
    check("fill_count", count, 4);

    // Non-head match must miss; head match hits and frees a slot.
    force_lk = 1;
    force_lk_label = 27'h102;
    step();
    force_lk_label = 27'h101;
    step();
    force_lk = 0;
    repeat (20) step();
    check("refill_bursts", n_ar, 5);

    // Restart on beat 3 of an in-flight burst.
    p_lookup = 100;
    repeat (6) step();
    p_lookup = 0;
    for (int i = 0; i < 100 && !(os && os_beat == 3); i++) step();
    check("mid_burst_reach", os && os_beat == 3, 1);
    force_rs = 1;
    force_rs_label = 27'h500;
    step();
    force_rs = 0;
    repeat (40) step();

    // Restart with all-ones label colliding with a head hit.
    for (int i = 0; i < 100 && mq.size() == 0; i++) step();
    check("have_head", mq.size() > 0, 1);
    force_rs = 1;
    force_rs_label = '1;
    force_lk = 1;
    force_lk_label = (mq.size() > 0) ? mq[0] : '0;
    step();
    force_rs = 0;
    force_lk = 0;
    repeat (40) step();

    // Random phases.
    p_restart = 10;
    p_lookup  = 8;
    p_arready = 70;
    p_rvalid  = 85;
    repeat (1500) step();
    p_arready = 15;
    p_rvalid  = 50;
    p_lookup  = 40;
    repeat (1200) step();
    p_arready = 90;
    p_rvalid  = 100;
    p_lookup  = 25;
    p_restart = 20;
    repeat (1200) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stream_buffer_multi.md
Name: stream_buffer_multi

Overview:
- Parametrised successor to the single-line prefetch stream buffer.
- Holds up to DEPTH sequentially prefetched cache lines in a circular queue and keeps fetching ahead over an AXI3 read master.
- The cache probes the queue head each miss; a hit returns the line and refills the freed slot.
- A restart flushes the stream and re-aims it at a new label; a burst already in flight is drained safely.

Parameters:
- LINE_WIDTH, 256, cache line width in bits (multiple of 32).
- DEPTH, 4, number of line entries (power of two, >=2).
- ARID, 2, AXI ID driven on arid (IDs 0 and 1 belong to icache/dcache).
- LINE_BYTE_OFFSET, $clog2(LINE_WIDTH/8), localparam.
- LABEL_WIDTH, $bits(phys_t)-LINE_BYTE_OFFSET, localparam, tag+index width.
- BURST_LEN, LINE_WIDTH/32, localparam, beats per line.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- restart  in  1  pulse: flush the stream and restart at restart_label+1.
- restart_label  in  LABEL_WIDTH  miss label that triggers the restart.
- lookup_req  in  1  cache probe valid.
- lookup_label  in  LABEL_WIDTH  probed label.
- hit  out  1  head entry matches the probe (combinational).
- hit_data  out  LINE_WIDTH  head entry line data, meaningful when hit=1.
- count  out  $clog2(DEPTH)+1  number of valid entries.
- axi3_rd_if  axi3_rd_if.master  AXI3 read channel (arid, axi3_rd_req, axi3_rd_resp).

Behaviour:
- Reset (sync, rst=1): all entry valids cleared; head_ptr=fill_ptr=0; count=0; state=IDLE; next_label=0; stream_on=0. Outputs after reset: hit=0, arvalid=0, rready=0.
- The buffer is inactive until the first restart. After a restart, stream_on=1 and the buffer fetches continuously while any slot is free.
- Constant AXI fields:
  - arid=ARID, arlen=BURST_LEN-1, arsize=3'b010, arburst=2'b01 (INCR).
  - All other request fields are 0 unless stated below.
  - araddr={next_label, LINE_BYTE_OFFSET zeros}.
- State machine (states in package enum sb_state_t):
  - IDLE:
    - If stream_on and count<DEPTH (counting the pop in progress) -> WAIT_AXI_READY.
    - The fetch label is latched into fill_label, the slot is fill_ptr.
  - WAIT_AXI_READY:
    - arvalid=1; araddr is held stable until arready.
    - On arready -> RECEIVING; beat counter=0.
  - RECEIVING:
    - rready=1.
    - Each rvalid beat writes rdata to word[beat] of slot fill_ptr; beat counter increments.
    - On rvalid&rlast: slot becomes valid with label fill_label; fill_ptr+=1 (mod DEPTH); next_label+=1 (mod 2^LABEL_WIDTH) -> IDLE.
  - DRAIN:
    - rready=1; beats are discarded and no entry is written.
    - On rvalid&rlast -> IDLE.
- Lookup:
  - hit = lookup_req & valid[head_ptr] & (label[head_ptr]==lookup_label) & ~restart.
  - hit_data = data[head_ptr], with zero-cycle latency.
  - On hit, the head is invalidated at the next edge; head_ptr+=1 (mod DEPTH); count-=1.
  - Non-head entries are never matched.
- Restart (highest priority):
  - All valids are cleared; head_ptr=fill_ptr=0; count=0; next_label=restart_label+1 (wraps at all-ones to 0).
  - A hit in the same cycle is suppressed.
  - Restart in IDLE -> IDLE. The new fetch is issued the next cycle.
  - Restart in WAIT_AXI_READY with arready=0: the request has not been accepted. araddr switches to the new next_label on the next cycle and arvalid stays high (the AXI stability rule is waived only for this unaccepted request).
  - Restart in WAIT_AXI_READY with arready=1 -> DRAIN.
  - Restart in RECEIVING -> DRAIN (-> IDLE if the restart cycle carries rlast). The partial line is never marked valid.
  - Restart in DRAIN: stay in DRAIN, update next_label only.
- Simultaneous events:
  - Pop (hit) and commit (rlast) in the same cycle: count is unchanged.
  - When full (count=DEPTH), the FSM stays in IDLE; a pop that cycle allows WAIT_AXI_READY the next cycle.
- Only one AXI burst is ever outstanding. rready is never asserted outside RECEIVING/DRAIN.
- count is registered and never exceeds DEPTH.

Decomposition:
- Package (stream_buffer.svh): sb_state_t {IDLE, WAIT_AXI_READY, RECEIVING, DRAIN}; sb_entry_t struct {valid, label, line}; the AXI constant values for arsize/arburst.
- Sub-module sb_entry_queue: DEPTH-entry storage with head/fill pointers, count, beat write port, commit/pop/flush. The top level keeps the FSM and AXI handshakes.

Test Plan:
- Config for all scenarios: LINE_WIDTH=256, DEPTH=4, 32-bit phys_t.
- Reset then restart label 0x100: four bursts araddr 0x2020, 0x2040, 0x2060, 0x2080, arlen=7; count reaches 4; no fifth arvalid.
- Full buffer, lookup 0x101 -> hit=1 with hit_data=beats of 0x2020; next cycle count=3; araddr 0x20A0 issued next.
- Lookup 0x102 while head is 0x101 -> hit=0 and the buffer is unchanged, even though the matching entry is present at a non-head slot.
- Restart label 0x500 on beat 3 of a burst: remaining beats accepted with rready=1 and dropped; after rlast, next araddr=0xA020; count=0 throughout.
- Restart with lookup hit in the same cycle -> hit=0; restart_label all-ones -> next_label wraps to 0 and araddr=0x0.
- Hit on the cycle rlast commits the 4th line -> count stays 3; arready held low 5 cycles -> araddr/arvalid stable all 5 cycles.
